// File: rtl/rosetta_pkg.sv
// rosetta_pkg
//   Constants shared by the ROSETTA job sequencer and the work state machine
//   it drives.
//   - Sequencer state encoding (3-bit, kept as plain constants so older
//     netlists and probes that decode the raw value keep working).
//   - Work machine state values as seen on the core_state wire.
//   - A small decode helper for the busy indication.
package rosetta_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_ACK   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WORK = 1'b1;

    // Busy covers every state that belongs to a batch in flight.
    function automatic logic state_is_busy(input logic [2:0] s);
        return (s != S_IDLE) && (s != S_ERR);
    endfunction

endpackage

// File: rtl/rosetta_watchdog.sv
// rosetta_watchdog
//   Saturating up-counter with synchronous clear and count enable. expired is
//   high while the count equals LIMIT; the count never moves past LIMIT.
//   Ports:
//     clk      rising-edge clock
//     rst_n    synchronous active-low reset
//     clr      clear count to zero (has priority over en)
//     en       count one step this cycle
//     expired  count has reached LIMIT
module rosetta_watchdog #(
    parameter int              TO_W  = 16,
    parameter logic [TO_W-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt < LIMIT)) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/rosetta_job_sequencer.sv
// rosetta_job_sequencer
//   Host-side initiator for the ROSETTA start/done protocol. Takes a batch of
//   cmd_count jobs, fires one start pulse per job, follows core_state to see
//   each job accepted and finished, and counts completions. A per-job
//   watchdog catches a hung job, requests abort and parks in ERR until
//   err_clr.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     cmd_valid    batch command offered
//     cmd_ready    accepting a command (IDLE only)
//     cmd_count    jobs in the batch, latched on handshake
//     start        one-cycle job start pulse to the work machine
//     core_state   work machine state (ST_IDLE / ST_WORK)
//     busy         batch in flight
//     jobs_done    completed jobs of the current / last batch
//     batch_done   one-cycle pulse when the batch finishes
//     err          sticky error (ACK timeout or watchdog expiry)
//     err_clr      leave ERR and clear err
//     abort        one-cycle pulse on watchdog expiry
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a command; zero-count commands finish here
//   ISSUE  | start is high for this one cycle
//   ACK    | up to two cycles waiting for core_state to go to Work
//   RUN    | job in progress, watchdog counting Work cycles
//   GAP    | GAP_CYCLES idle cycles before the next start
//   ERR    | hung or unacknowledged job; wait for err_clr
module rosetta_job_sequencer
    import rosetta_pkg::*;
#(
    parameter int          CNT_W      = 8,
    parameter int          TO_W       = 16,
    parameter int unsigned TIMEOUT    = 16'hFFFF,
    parameter int          GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             start,
    input  logic             core_state,
    output logic             busy,
    output logic [CNT_W-1:0] jobs_done,
    output logic             batch_done,
    output logic             err,
    input  logic             err_clr,
    output logic             abort
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    // Gap counter runs down from GAP_CYCLES-1 to 0; unused when GAP_CYCLES=0.
    localparam logic [3:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] job_total;
    logic [3:0]       gap_cnt;
    logic             ack_late;

    logic             handshake;
    logic             job_fin;
    logic             last_job;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expired;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = state_is_busy(state);

    assign handshake = cmd_valid && cmd_ready;
    assign job_fin   = (state == S_RUN) && (core_state == ST_IDLE);
    assign last_job  = ((jobs_done + CNT_W'(1)) == job_total);

    // Watchdog is held clear while waiting for acceptance, so it starts
    // from zero on the first RUN cycle.
    assign wd_clr = (state == S_ACK);
    assign wd_en  = (state == S_RUN) && (core_state == ST_WORK);

    rosetta_watchdog #(
        .TO_W  (TO_W),
        .LIMIT (TO_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (handshake && (cmd_count != '0)) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_ACK;
            end
            S_ACK: begin
                if (core_state == ST_WORK) begin
                    state_nx = S_RUN;
                end else if (ack_late) begin
                    state_nx = S_ERR;
                end
            end
            S_RUN: begin
                // Completion is tested first so it wins over a same-cycle expiry.
                if (core_state == ST_IDLE) begin
                    if (last_job) begin
                        state_nx = S_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = S_GAP;
                    end
                end else if (wd_expired) begin
                    state_nx = S_ERR;
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start      <= 1'b0;
            batch_done <= 1'b0;
            abort      <= 1'b0;
            err        <= 1'b0;
            jobs_done  <= '0;
            job_total  <= '0;
            gap_cnt    <= 4'd0;
            ack_late   <= 1'b0;
        end else begin
            state      <= state_nx;
            start      <= (state_nx == S_ISSUE);
            batch_done <= (handshake && (cmd_count == '0)) || (job_fin && last_job);
            abort      <= (state == S_RUN) && (state_nx == S_ERR);
            err        <= (state_nx == S_ERR);
            // High on the second ACK cycle only.
            ack_late   <= (state == S_ACK);

            if (handshake) begin
                job_total <= cmd_count;
                jobs_done <= '0;
            end else if (job_fin) begin
                jobs_done <= jobs_done + CNT_W'(1);
            end

            if ((state_nx == S_GAP) && (state != S_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_rosetta_job_sequencer.sv
module tb_rosetta_job_sequencer;

    localparam int CNT_W   = 8;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             err_clr = 1'b0;
    logic             core_state = 1'b0;
    logic             cmd_ready;
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] jobs_done;
    logic             batch_done;
    logic             err;
    logic             abort;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rosetta_job_sequencer #(
        .CNT_W      (CNT_W),
        .TO_W       (TO_W),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_count  (cmd_count),
        .start      (start),
        .core_state (core_state),
        .busy       (busy),
        .jobs_done  (jobs_done),
        .batch_done (batch_done),
        .err        (err),
        .err_clr    (err_clr),
        .abort      (abort)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Work machine model: registers start, stays in Work for W cycles.
    int w_arr[16];
    int w_base = 0;
    int model_jobs = 0;
    int rem = 0;
    bit never_work = 1'b0;

    always @(posedge clk) begin
        if (!rst_n || abort) begin
            core_state <= 1'b0;
            rem <= 0;
        end else if (!core_state) begin
            if (start && !never_work) begin
                core_state <= 1'b1;
                rem <= w_arr[model_jobs - w_base] - 1;
                model_jobs <= model_jobs + 1;
            end
        end else if (rem == 0) begin
            core_state <= 1'b0;
        end else begin
            rem <= rem - 1;
        end
    end

    // Event log, sampled mid-cycle.
    int start_cyc[$];
    int bd_cyc[$];
    int ab_cyc[$];
    int err_rise[$];
    logic err_q = 1'b0;

    always @(negedge clk) begin
        if (start === 1'b1) start_cyc.push_back(cyc);
        if (batch_done === 1'b1) bd_cyc.push_back(cyc);
        if (abort === 1'b1) ab_cyc.push_back(cyc);
        if (err === 1'b1 && err_q !== 1'b1) err_rise.push_back(cyc);
        err_q = err;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: start of job i+1 is W_i + 2 + GAP cycles after start of job i;
    // batch_done is W + 2 cycles after the last start; a job longer than
    // TIMEOUT+1 Work cycles aborts TIMEOUT+3 cycles after its start.
    task automatic run_batch(input int n, input bit poke, input string tag);
        int exp_st[$];
        int t, exp_done, exp_bd, exp_ab, sb, bb, ab, c0;
        bit seen;
        t = 1; exp_done = 0; exp_bd = 0; exp_ab = 0;
        if (n == 0) exp_bd = 1;
        for (int i = 0; i < n; i++) begin
            exp_st.push_back(t);
            if (w_arr[i] > TIMEOUT + 1) begin
                exp_ab = t + TIMEOUT + 3;
                break;
            end
            exp_done++;
            if (i == n - 1) exp_bd = t + w_arr[i] + 2;
            else t = t + w_arr[i] + 2 + GAP;
        end

        @(negedge clk);
        check({tag, "_ready"}, int'(cmd_ready), 1);
        sb = start_cyc.size(); bb = bd_cyc.size(); ab = ab_cyc.size();
        w_base = model_jobs;
        cmd_valid = 1'b1;
        cmd_count = n[CNT_W-1:0];
        @(negedge clk);
        c0 = cyc;
        cmd_valid = 1'b0;

        seen = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (poke && k == 3) begin
                cmd_valid = 1'b1; cmd_count = 8'd9; err_clr = 1'b1;
            end
            if (poke && k == 5) begin
                cmd_valid = 1'b0; err_clr = 1'b0;
            end
            if (bd_cyc.size() > bb || ab_cyc.size() > ab) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        err_clr = 1'b0;
        check({tag, "_finished"}, int'(seen), 1);
        repeat (3) @(negedge clk);

        check({tag, "_nstart"}, start_cyc.size() - sb, exp_st.size());
        for (int i = 0; i < exp_st.size() && i < start_cyc.size() - sb; i++)
            check($sformatf("%s_start%0d", tag, i), start_cyc[sb + i] - c0 + 1, exp_st[i]);
        check({tag, "_nbd"}, bd_cyc.size() - bb, (exp_bd > 0) ? 1 : 0);
        if (exp_bd > 0 && bd_cyc.size() > bb)
            check({tag, "_bd_cyc"}, bd_cyc[bb] - c0 + 1, exp_bd);
        check({tag, "_nabort"}, ab_cyc.size() - ab, (exp_ab > 0) ? 1 : 0);
        if (exp_ab > 0 && ab_cyc.size() > ab)
            check({tag, "_abort_cyc"}, ab_cyc[ab] - c0 + 1, exp_ab);
        check({tag, "_jobs_done"}, int'(jobs_done), exp_done);
        check({tag, "_err"}, int'(err), (exp_ab > 0) ? 1 : 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic clear_err(input string tag);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin : watchdog_guard
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int sb, ab, eb, c0, n, hold_done;
        bit seen;

        // Reset state, while held and right after release.
        repeat (3) @(negedge clk);
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_abort", int'(abort), 0);
        check("rst_bd", int'(batch_done), 0);
        check("rst_jobs_done", int'(jobs_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(cmd_ready), 1);

        // Three jobs of 5 Work cycles; cmd_valid and err_clr poked during RUN.
        for (int j = 0; j < 3; j++) w_arr[j] = 5;
        run_batch(3, 1'b1, "b3");

        // err_clr while idle has no effect.
        @(negedge clk);
        sb = start_cyc.size();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("idle_clr_ready", int'(cmd_ready), 1);
        check("idle_clr_busy", int'(busy), 0);
        check("idle_clr_err", int'(err), 0);
        check("idle_clr_jobs", int'(jobs_done), 3);
        check("idle_clr_nstart", start_cyc.size() - sb, 0);

        // Zero-count batch.
        run_batch(0, 1'b0, "zero");

        // Work machine never acknowledges.
        never_work = 1'b1;
        @(negedge clk);
        sb = start_cyc.size(); ab = ab_cyc.size(); eb = err_rise.size();
        cmd_valid = 1'b1;
        cmd_count = 8'd2;
        @(negedge clk);
        c0 = cyc;
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (err_rise.size() > eb) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("noack_seen", int'(seen), 1);
        if (seen) check("noack_err_cyc", err_rise[eb] - c0 + 1, 4);
        repeat (2) @(negedge clk);
        check("noack_err", int'(err), 1);
        check("noack_busy", int'(busy), 0);
        check("noack_ready", int'(cmd_ready), 0);
        check("noack_nabort", ab_cyc.size() - ab, 0);
        check("noack_nstart", start_cyc.size() - sb, 1);
        check("noack_jobs", int'(jobs_done), 0);
        never_work = 1'b0;
        clear_err("noack_clr");

        // Second job one cycle past the watchdog limit.
        w_arr[0] = 4; w_arr[1] = TIMEOUT + 2; w_arr[2] = 5;
        run_batch(3, 1'b0, "tmo");
        clear_err("tmo_clr");

        // Completion lands on the expiry cycle: counted as done.
        w_arr[0] = TIMEOUT + 1; w_arr[1] = 3;
        run_batch(2, 1'b0, "edge");

        // Reset during RUN of job 2 of 4.
        for (int j = 0; j < 4; j++) w_arr[j] = 6;
        @(negedge clk);
        sb = start_cyc.size(); ab = ab_cyc.size();
        w_base = model_jobs;
        cmd_valid = 1'b1;
        cmd_count = 8'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (start_cyc.size() >= sb + 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_second_start", int'(seen), 1);
        repeat (4) @(negedge clk);
        hold_done = int'(jobs_done);
        check("mid_pre_jobs", hold_done, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_start", int'(start), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_ready", int'(cmd_ready), 1);
        check("mid_jobs", int'(jobs_done), 0);
        rst_n = 1'b1;
        sb = start_cyc.size();
        repeat (40) @(negedge clk);
        check("mid_nstart", start_cyc.size() - sb, 0);
        check("mid_nabort", ab_cyc.size() - ab, 0);

        // Randomised batches against the reference.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(4, 1));
            for (int j = 0; j < n; j++) w_arr[j] = int'($urandom_range(TIMEOUT + 4, 1));
            run_batch(n, 1'b0, $sformatf("rnd%0d", r));
            if (err) clear_err($sformatf("rnd%0d_clr", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
